// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StSave,
    StRedirect,
    StRet
  } trap_state_e;

  // mcause exception codes
  localparam logic [4:0] CauseInstrMisaligned = 5'd0;
  localparam logic [4:0] CauseInstrFault      = 5'd1;
  localparam logic [4:0] CauseLoadMisaligned  = 5'd4;
  localparam logic [4:0] CauseLoadFault       = 5'd5;
  localparam logic [4:0] CauseStoreMisaligned = 5'd6;
  localparam logic [4:0] CauseStoreFault      = 5'd7;
  localparam logic [4:0] CauseEcall           = 5'd11;

  // mcause interrupt codes
  localparam logic [4:0] CauseMsi = 5'd3;
  localparam logic [4:0] CauseMti = 5'd7;
  localparam logic [4:0] CauseMei = 5'd11;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  localparam int unsigned ExcInstrMisaligned = 0;
  localparam int unsigned ExcInstrFault      = 1;
  localparam int unsigned ExcLoadMisaligned  = 2;
  localparam int unsigned ExcStoreMisaligned = 3;
  localparam int unsigned ExcLoadFault       = 4;
  localparam int unsigned ExcStoreFault      = 5;
  localparam int unsigned ExcEcall           = 6;

  localparam int unsigned IrqMsip = 0;
  localparam int unsigned IrqMtip = 1;
  localparam int unsigned IrqMeip = 2;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap source selection: exceptions first, then enabled interrupts.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic [6:0] i_exc_vec,
  input  logic [2:0] i_irq_vec,
  input  logic [2:0] i_mie,
  input  logic       i_mstatus_mie,
  output logic       o_valid,
  output logic       o_is_irq,
  output logic [4:0] o_cause,
  output logic       o_src_if
);

  logic [2:0] w_irq_pend;

  assign w_irq_pend = i_irq_vec & i_mie & {3{i_mstatus_mie}};

  always_comb begin
    o_valid  = 1'b1;
    o_is_irq = 1'b0;
    o_cause  = 5'd0;
    o_src_if = 1'b0;
    if (i_exc_vec[ExcStoreMisaligned]) begin
      o_cause = CauseStoreMisaligned;
    end else if (i_exc_vec[ExcLoadMisaligned]) begin
      o_cause = CauseLoadMisaligned;
    end else if (i_exc_vec[ExcStoreFault]) begin
      o_cause = CauseStoreFault;
    end else if (i_exc_vec[ExcLoadFault]) begin
      o_cause = CauseLoadFault;
    end else if (i_exc_vec[ExcEcall]) begin
      o_cause = CauseEcall;
    end else if (i_exc_vec[ExcInstrMisaligned]) begin
      o_cause  = CauseInstrMisaligned;
      o_src_if = 1'b1;
    end else if (i_exc_vec[ExcInstrFault]) begin
      o_cause  = CauseInstrFault;
      o_src_if = 1'b1;
    end else if (w_irq_pend[IrqMeip]) begin
      o_is_irq = 1'b1;
      o_cause  = CauseMei;
    end else if (w_irq_pend[IrqMsip]) begin
      o_is_irq = 1'b1;
      o_cause  = CauseMsi;
    end else if (w_irq_pend[IrqMtip]) begin
      o_is_irq = 1'b1;
      o_cause  = CauseMti;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer with mepc/mcause/mtval/mtvec/mstatus/mie CSRs.
// Define TRAP_VECTORED_EN to enable vectored interrupt dispatch when mtvec[0]=1.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] IF_PC,
  input  logic [31:0] EXE_PC,
  input  logic [31:0] EXE_aluout,
  input  logic [6:0]  exc_vec,
  input  logic [2:0]  irq_vec,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        ID_flush,
  output logic        EXE_flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic [31:0] mtvec,
  output logic        mstatus_mie
);

  trap_state_e r_state;
  logic        r_flush;
  logic        r_stall;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_mtvec;
  logic [2:0]  r_mie;
  logic        r_mstatus_mie;
  logic        r_mpie;
  logic        r_lat_irq;
  logic [4:0]  r_lat_cause;
  logic [31:0] r_lat_epc;
  logic [31:0] r_lat_tval;

  logic        w_trap_valid;
  logic        w_trap_irq;
  logic [4:0]  w_trap_cause;
  logic        w_trap_src_if;
  logic [31:0] w_epc;
  logic [31:0] w_tval;
  logic [31:0] w_trap_pc;

  trap_prio_enc u_prio_enc (
    .i_exc_vec     (exc_vec),
    .i_irq_vec     (irq_vec),
    .i_mie         (r_mie),
    .i_mstatus_mie (r_mstatus_mie),
    .o_valid       (w_trap_valid),
    .o_is_irq      (w_trap_irq),
    .o_cause       (w_trap_cause),
    .o_src_if      (w_trap_src_if)
  );

  assign w_epc = w_trap_src_if ? IF_PC : EXE_PC;

  always_comb begin
    w_tval = EXE_aluout;
    if (w_trap_irq) begin
      w_tval = 32'd0;
    end else if (w_trap_src_if) begin
      w_tval = IF_PC;
    end else if (w_trap_cause == CauseEcall) begin
      w_tval = 32'd0;
    end
  end

  always_comb begin
    w_trap_pc = {r_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (r_mtvec[0] && r_lat_irq) begin
      w_trap_pc = w_trap_pc + {25'd0, r_lat_cause, 2'b00};
    end
`endif
  end

  // CSR port writes first; FSM updates later in the block override same-register writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state          <= StIdle;
      r_flush          <= 1'b0;
      r_stall          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_mepc           <= 32'd0;
      r_mcause         <= 32'd0;
      r_mtval          <= 32'd0;
      r_mtvec          <= 32'd0;
      r_mie            <= 3'd0;
      r_mstatus_mie    <= 1'b0;
      r_mpie           <= 1'b0;
      r_lat_irq        <= 1'b0;
      r_lat_cause      <= 5'd0;
      r_lat_epc        <= 32'd0;
      r_lat_tval       <= 32'd0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CsrMstatus: begin
            r_mstatus_mie <= csr_wdata[MstatusMieBit];
            r_mpie        <= csr_wdata[MstatusMpieBit];
          end
          CsrMie:   r_mie   <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
          CsrMtvec: r_mtvec <= csr_wdata;
          CsrMepc:  r_mepc  <= csr_wdata;
          default:  ;
        endcase
      end

      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;

      unique case (r_state)
        StIdle: begin
          r_stall <= 1'b0;
          if (w_trap_valid) begin
            r_state     <= StFlush;
            r_flush     <= 1'b1;
            r_stall     <= 1'b1;
            r_lat_irq   <= w_trap_irq;
            r_lat_cause <= w_trap_cause;
            r_lat_epc   <= w_epc;
            r_lat_tval  <= w_tval;
          end else if (mret) begin
            r_state          <= StRet;
            r_flush          <= 1'b1;
            r_stall          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_mepc;
            r_mstatus_mie    <= r_mpie;
            r_mpie           <= 1'b1;
          end
        end
        StFlush: begin
          r_state <= StSave;
        end
        StSave: begin
          r_state          <= StRedirect;
          r_mepc           <= r_lat_epc;
          r_mcause         <= {r_lat_irq, 26'd0, r_lat_cause};
          r_mtval          <= r_lat_tval;
          r_mpie           <= r_mstatus_mie;
          r_mstatus_mie    <= 1'b0;
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_trap_pc;
        end
        StRedirect: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
        StRet: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign ID_flush       = r_flush;
  assign EXE_flush      = r_flush;
  assign stall          = r_stall;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign mepc           = r_mepc;
  assign mcause         = r_mcause;
  assign mtval          = r_mtval;
  assign mtvec          = r_mtvec;
  assign mstatus_mie    = r_mstatus_mie;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: drivers queue expected redirects, a monitor checks them.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] IF_PC, EXE_PC, EXE_aluout;
  logic [6:0]  exc_vec;
  logic [2:0]  irq_vec;
  logic        mret, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        ID_flush, EXE_flush, stall, redirect_valid;
  logic [31:0] redirect_pc, mepc, mcause, mtval, mtvec;
  logic        mstatus_mie;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mie;
    logic        flush;
  } exp_t;

  typedef struct {
    logic [6:0]  exc;
    logic [31:0] if_pc;
    logic [31:0] exe_pc;
    logic [31:0] alu;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t tbl[6];

  trap_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .IF_PC          (IF_PC),
    .EXE_PC         (EXE_PC),
    .EXE_aluout     (EXE_aluout),
    .exc_vec        (exc_vec),
    .irq_vec        (irq_vec),
    .mret           (mret),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .ID_flush       (ID_flush),
    .EXE_flush      (EXE_flush),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mepc           (mepc),
    .mcause         (mcause),
    .mtval          (mtval),
    .mtvec          (mtvec),
    .mstatus_mie    (mstatus_mie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_we = 1'b0;
  endtask

  // Trap inputs must already be applied; optional noise during FLUSH/SAVE must be ignored.
  task automatic trap_seq(input logic [31:0] pc_e, input logic [31:0] mepc_e,
                          input logic [31:0] mcause_e, input logic [31:0] mtval_e,
                          input bit noisy);
    exp_t x;
    x = '{pc_e, mepc_e, mcause_e, mtval_e, 1'b0, 1'b0};
    q.push_back(x);
    tick();
    exc_vec = '0; irq_vec = '0; mret = 1'b0;
    chk("flush_id", {31'd0, ID_flush}, 32'd1);
    chk("flush_exe", {31'd0, EXE_flush}, 32'd1);
    chk("stall_flush", {31'd0, stall}, 32'd1);
    chk("no_early_redirect", {31'd0, redirect_valid}, 32'd0);
    if (noisy) begin
      exc_vec = 7'h7F; irq_vec = 3'h7; mret = 1'b1;
    end
    tick();
    chk("flush_one_cycle", {31'd0, ID_flush}, 32'd0);
    chk("stall_save", {31'd0, stall}, 32'd1);
    if (noisy) begin
      csr_we = 1'b1; csr_addr = CsrMepc; csr_wdata = 32'hDEAD_BEEF;
    end
    tick();
    exc_vec = '0; irq_vec = '0; mret = 1'b0; csr_we = 1'b0;
    chk("redirect_timing", {31'd0, redirect_valid}, 32'd1);
    chk("stall_redirect", {31'd0, stall}, 32'd1);
    tick();
    chk("stall_idle", {31'd0, stall}, 32'd0);
    chk("redirect_pulse", {31'd0, redirect_valid}, 32'd0);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("stays_idle", {31'd0, stall}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_redirect: got redirect_pc 0x%08h, required no redirect",
                 redirect_pc);
      end else begin
        e = q.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("mepc", mepc, e.mepc);
        chk("mcause", mcause, e.mcause);
        chk("mtval", mtval, e.mtval);
        chk("mstatus_mie", {31'd0, mstatus_mie}, {31'd0, e.mie});
        chk("redirect_flush", {31'd0, ID_flush}, {31'd0, e.flush});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    tbl[0] = '{7'h50, 32'h0, 32'h94, 32'h500, 32'd5, 32'h94, 32'h500};
    tbl[1] = '{7'h24, 32'h0, 32'h98, 32'h601, 32'd4, 32'h98, 32'h601};
    tbl[2] = '{7'h70, 32'h0, 32'h9C, 32'h702, 32'd7, 32'h9C, 32'h702};
    tbl[3] = '{7'h03, 32'h2002, 32'hA0, 32'h1, 32'd0, 32'h2002, 32'h2002};
    tbl[4] = '{7'h02, 32'h3000, 32'hA4, 32'h2, 32'd1, 32'h3000, 32'h3000};
    tbl[5] = '{7'h41, 32'h4002, 32'hA8, 32'h3, 32'd11, 32'hA8, 32'h0};

    rstn = 1'b0; IF_PC = '0; EXE_PC = '0; EXE_aluout = '0; exc_vec = '0; irq_vec = '0;
    mret = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    tick(); tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, ID_flush}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_mtvec", mtvec, 32'd0);
    rstn = 1'b1;

    // Scenario 1: load misaligned
    csr_write(CsrMtvec, 32'h200);
    EXE_PC = 32'h40; EXE_aluout = 32'h102; exc_vec = 7'h04;
    trap_seq(32'h200, 32'h40, 32'd4, 32'h102, 1'b0);

    // Scenario 2 with noise during FLUSH/SAVE, including a mepc write in SAVE
    IF_PC = 32'h1000; EXE_PC = 32'h80; EXE_aluout = 32'h333; exc_vec = 7'h0A;
    trap_seq(32'h200, 32'h80, 32'd6, 32'h333, 1'b1);
    idle_check(2);

    // mret and ecall together: exception wins
    EXE_PC = 32'h88; exc_vec = 7'h40; mret = 1'b1;
    trap_seq(32'h200, 32'h88, 32'd11, 32'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      IF_PC = tbl[i].if_pc; EXE_PC = tbl[i].exe_pc; EXE_aluout = tbl[i].alu;
      exc_vec = tbl[i].exc;
      trap_seq(32'h200, tbl[i].epc, tbl[i].cause, tbl[i].tval, 1'b0);
    end

    // Scenario 3: timer interrupt
    csr_write(CsrMstatus, 32'h08);
    csr_write(CsrMie, 32'h80);
    EXE_PC = 32'hB0; EXE_aluout = 32'h55; irq_vec = 3'b010;
    trap_seq(32'h200, 32'hB0, 32'h8000_0007, 32'd0, 1'b0);
    irq_vec = 3'b010;
    idle_check(4);
    irq_vec = '0;

    // Scenario 4: mret restores MIE from MPIE
    csr_write(CsrMepc, 32'h44);
    mret = 1'b1;
    r = '{32'h44, 32'h44, 32'h8000_0007, 32'd0, 1'b1, 1'b1};
    q.push_back(r);
    tick();
    mret = 1'b0;
    chk("ret_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("ret_done_stall", {31'd0, stall}, 32'd0);
    chk("ret_mie", {31'd0, mstatus_mie}, 32'd1);

    // Interrupt priority
    csr_write(CsrMie, 32'h888);
    EXE_PC = 32'hB4; irq_vec = 3'b111;
    trap_seq(32'h200, 32'hB4, 32'h8000_000B, 32'd0, 1'b0);
    csr_write(CsrMstatus, 32'h08);
    irq_vec = 3'b011;
    trap_seq(32'h200, 32'hB4, 32'h8000_0003, 32'd0, 1'b0);
    csr_write(CsrMstatus, 32'h08);
    csr_write(CsrMie, 32'h808);
    irq_vec = 3'b010;
    idle_check(3);
    EXE_PC = 32'hB8; exc_vec = 7'h40; irq_vec = 3'b001;
    trap_seq(32'h200, 32'hB8, 32'd11, 32'd0, 1'b0);

    // Scenario 6: vectored interrupt and base for exceptions
    csr_write(CsrMstatus, 32'h08);
    csr_write(CsrMie, 32'h800);
    csr_write(CsrMtvec, 32'h201);
    EXE_PC = 32'hC0; irq_vec = 3'b100;
`ifdef TRAP_VECTORED_EN
    trap_seq(32'h22C, 32'hC0, 32'h8000_000B, 32'd0, 1'b0);
`else
    trap_seq(32'h200, 32'hC0, 32'h8000_000B, 32'd0, 1'b0);
`endif
    EXE_PC = 32'hC4; EXE_aluout = 32'h7; exc_vec = 7'h04;
    trap_seq(32'h200, 32'hC4, 32'd4, 32'h7, 1'b0);

    // Reset during FLUSH abandons the trap
    exc_vec = 7'h04;
    tick();
    exc_vec = '0;
    chk("pre_rst_flush", {31'd0, ID_flush}, 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_flush", {31'd0, EXE_flush}, 32'd0);
    chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("midrst_mepc", mepc, 32'd0);
    chk("midrst_mcause", mcause, 32'd0);
    chk("midrst_mtval", mtval, 32'd0);
    chk("midrst_mtvec", mtvec, 32'd0);
    chk("midrst_mie", {31'd0, mstatus_mie}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_redirect", {31'd0, redirect_valid}, 32'd0);
    end

    // MPIE is 0 after reset: mret returns to 0 with MIE=0
    mret = 1'b1;
    r = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    q.push_back(r);
    tick();
    mret = 1'b0;
    tick(); tick();

    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
